// File: rtl/simon_playback_ctrl.sv
// Simon Says pattern playback: fetches one colour per step from pattern RAM
// and drives the LED decoder with ON/OFF timing, pulsing done at the end.
module simon_playback_ctrl #(
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned ON_CYCLES  = 25000000,
    parameter int unsigned OFF_CYCLES = 12500000,
    parameter int unsigned CNT_W      = 25
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   seq_len,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [1:0]        pat_data,
    output logic [1:0]        led_idx,
    output logic              led_en,
    output logic              busy,
    output logic              done
);

    localparam int unsigned LEN_W   = ADDR_W + 1;
    localparam int unsigned MAX_LEN = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_ON,
        S_GAP,
        S_DONE
    } state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   step, step_nxt;
    logic [LEN_W-1:0]    len, len_nxt;
    logic [CNT_W-1:0]    timer, timer_nxt;
    logic                rd_en_nxt;
    logic [ADDR_W-1:0]   rd_addr_nxt;
    logic [1:0]          led_idx_nxt;
    logic                led_en_nxt;
    logic                busy_nxt;
    logic                done_nxt;

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            step    <= '0;
            len     <= '0;
            timer   <= '0;
            rd_en   <= 1'b0;
            rd_addr <= '0;
            led_idx <= '0;
            led_en  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            step    <= step_nxt;
            len     <= len_nxt;
            timer   <= timer_nxt;
            rd_en   <= rd_en_nxt;
            rd_addr <= rd_addr_nxt;
            led_idx <= led_idx_nxt;
            led_en  <= led_en_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
        end
    end

    // Next-state logic; outputs are decoded from the next state so they register in step
    always_comb begin
        state_nxt   = state;
        step_nxt    = step;
        len_nxt     = len;
        timer_nxt   = timer;
        led_idx_nxt = led_idx;

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    if (seq_len != '0) begin
                        len_nxt   = (seq_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : seq_len;
                        step_nxt  = '0;
                        state_nxt = S_FETCH;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_FETCH: state_nxt = S_LATCH;
            S_LATCH: begin
                led_idx_nxt = pat_data;
                timer_nxt   = CNT_W'(ON_CYCLES - 1);
                state_nxt   = S_ON;
            end
            S_ON: begin
                if (timer == '0) begin
                    timer_nxt = CNT_W'(OFF_CYCLES - 1);
                    state_nxt = S_GAP;
                end else begin
                    timer_nxt = timer - CNT_W'(1);
                end
            end
            S_GAP: begin
                if (timer == '0) begin
                    if (LEN_W'(step) == len - LEN_W'(1)) begin
                        state_nxt = S_DONE;
                    end else begin
                        step_nxt  = step + ADDR_W'(1);
                        state_nxt = S_FETCH;
                    end
                end else begin
                    timer_nxt = timer - CNT_W'(1);
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        // Abort drops straight to idle without a done pulse; the LED colour is left as-is
        if (abort) begin
            state_nxt   = S_IDLE;
            led_idx_nxt = led_idx;
        end

        rd_en_nxt   = (state_nxt == S_FETCH);
        rd_addr_nxt = (state_nxt == S_FETCH) ? step_nxt : rd_addr;
        led_en_nxt  = (state_nxt == S_ON);
        busy_nxt    = (state_nxt == S_FETCH) || (state_nxt == S_LATCH) ||
                      (state_nxt == S_ON)    || (state_nxt == S_GAP);
        done_nxt    = (state_nxt == S_DONE);
    end

endmodule

// File: tb/tb_simon_playback_ctrl.sv
// Directed bench for simon_playback_ctrl with ON_CYCLES=3, OFF_CYCLES=2
// (7-cycle step period); compares a packed output word every cycle.
module tb_simon_playback_ctrl;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned PERIOD = 7;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              abort;
    logic [ADDR_W:0]   seq_len;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [1:0]        pat_data;
    logic [1:0]        led_idx;
    logic              led_en;
    logic              busy;
    logic              done;

    logic [1:0] mem [32];
    int n_vec = 0;
    int n_err = 0;

    simon_playback_ctrl #(
        .ADDR_W(ADDR_W), .ON_CYCLES(3), .OFF_CYCLES(2), .CNT_W(25)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .seq_len(seq_len),
        .rd_en(rd_en), .rd_addr(rd_addr), .pat_data(pat_data),
        .led_idx(led_idx), .led_en(led_en), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Pattern RAM model: data valid the cycle after rd_en
    always_ff @(posedge clk) begin
        if (rd_en) pat_data <= mem[rd_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] obs();
        return {rd_en, rd_addr, led_en, led_idx, busy, done};
    endfunction

    function automatic logic [10:0] pack(int re, int addr, int le, int idx, int bsy, int dn);
        return {1'(re), 5'(addr), 1'(le), 2'(idx), 1'(bsy), 1'(dn)};
    endfunction

    // Expected word k cycles after start is sampled, for a playback of len steps
    function automatic logic [10:0] expect_at(int k, int len, int prev_idx);
        int s, p, last_addr, last_idx;
        last_addr = (len == 0) ? 0 : len - 1;
        last_idx  = (len == 0) ? prev_idx : int'(mem[len-1]);
        if (k == len * PERIOD + 1) return pack(0, last_addr, 0, last_idx, 0, 1);
        if (k > len * PERIOD + 1)  return pack(0, last_addr, 0, last_idx, 0, 0);
        s = (k - 1) / PERIOD;
        p = (k - 1) % PERIOD;
        if (p <= 1)
            return pack((p == 0) ? 1 : 0, s, 0, (s == 0) ? prev_idx : int'(mem[s-1]), 1, 0);
        return pack(0, s, (p <= 4) ? 1 : 0, int'(mem[s]), 1, 0);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        repeat (2) @(negedge clk);
        check("reset", 32'(obs()), 32'(0));
        rst = 1'b0;
    endtask

    // Pulse start and compare cycles 1..stop_k; optional extra start/abort/rst at given cycles
    task automatic run_trace(input string name, input int slen, input int len, input int prev_idx,
                             input int stop_k, input int restart_k, input int abort_k,
                             input int rst_k);
        int reads;
        reads = 0;
        @(negedge clk);
        seq_len = (ADDR_W+1)'(slen);
        start   = 1'b1;
        for (int k = 1; k <= stop_k; k++) begin
            @(negedge clk);
            start   = (k == restart_k);
            abort   = (k == abort_k);
            rst     = (k == rst_k);
            seq_len = 6'd9;
            if (rd_en) reads++;
            check($sformatf("%s k=%0d", name, k), 32'(obs()), 32'(expect_at(k, len, prev_idx)));
        end
        if (stop_k >= len * PERIOD + 1)
            check({name, " reads"}, 32'(reads), 32'(len));
    endtask

    task automatic idle_watch(input string name, input int n, input logic [10:0] exp);
        @(negedge clk);
        start = 1'b0; abort = 1'b0; rst = 1'b0;
        check({name, " next"}, 32'(obs()), 32'(exp));
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (obs() !== exp) check($sformatf("%s idle %0d", name, i), 32'(obs()), 32'(exp));
        end
        n_vec++;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; seq_len = '0;
        for (int i = 0; i < 32; i++) mem[i] = 2'((i * 3 + 1) % 4);
        mem[0] = 2'd2; mem[1] = 2'd0; mem[2] = 2'd3;

        do_reset();
        run_trace("basic", 3, 3, 0, 23, 0, 0, 0);

        do_reset();
        run_trace("busy_start", 3, 3, 0, 23, 6, 0, 0);

        do_reset();
        run_trace("zero_len", 0, 0, 0, 3, 0, 0, 0);

        do_reset();
        run_trace("clamp", 40, 32, 0, 32 * PERIOD + 2, 0, 0, 0);

        do_reset();
        run_trace("abort", 3, 3, 0, 11, 0, 11, 0);
        idle_watch("abort", 30, pack(0, 1, 0, 0, 0, 0));
        run_trace("replay", 3, 3, 0, 23, 0, 0, 0);

        do_reset();
        run_trace("rst_mid", 3, 3, 0, 2, 0, 0, 2);
        idle_watch("rst_mid", 30, pack(0, 0, 0, 0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
